comparator_seq_nbit: RTL and testbench



---
 rtl/comparator_seq_nbit.sv | 117 +++++++++++
 tb/tb_comparator_seq_nbit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/comparator_seq_nbit.sv
// Multi-cycle MSB-first magnitude comparator (unsigned / two's-complement), start/busy/done handshake.
// Optional macro CMP_EARLY_EXIT_EN: finish on the first differing digit instead of after all K digits.
module comparator_seq_nbit #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             F1,
  output logic             F2,
  output logic             F3
);

  localparam int K    = WIDTH / DIGIT;
  localparam int IDXW = (K > 1) ? $clog2(K) : 1;

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
    $error("comparator_seq_nbit: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IDXW-1:0]  idx;
  logic             gt;
  logic             lt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic             gt_n;
  logic             lt_n;
  logic             last;
  logic             finish;

  // Shifting the current digit to the top avoids a variable-base part-select.
  always_comb begin
    a_sh   = a_q << (idx * DIGIT);
    b_sh   = b_q << (idx * DIGIT);
    a_dig  = a_sh[WIDTH-1 -: DIGIT];
    b_dig  = b_sh[WIDTH-1 -: DIGIT];
    gt_n   = gt | (~gt & ~lt & (a_dig > b_dig));
    lt_n   = lt | (~gt & ~lt & (a_dig < b_dig));
    last   = (idx == IDXW'(K - 1));
`ifdef CMP_EARLY_EXIT_EN
    finish = last | gt_n | lt_n;
`else
    finish = last;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      F1    <= 1'b0;
      F2    <= 1'b0;
      F3    <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      idx   <= '0;
      gt    <= 1'b0;
      lt    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            // Flipping the sign bit maps two's-complement order onto unsigned order.
            a_q   <= signed_mode ? {~A[WIDTH-1], A[WIDTH-2:0]} : A;
            b_q   <= signed_mode ? {~B[WIDTH-1], B[WIDTH-2:0]} : B;
            idx   <= '0;
            gt    <= 1'b0;
            lt    <= 1'b0;
            state <= RUN;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          gt  <= gt_n;
          lt  <= lt_n;
          idx <= idx + IDXW'(1);
          if (finish) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            F1    <= gt_n;
            F2    <= ~gt_n & ~lt_n;
            F3    <= lt_n;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_seq_nbit.sv
// Directed bench for comparator_seq_nbit (WIDTH=8, DIGIT=2); latency expectations follow CMP_EARLY_EXIT_EN.
module tb_comparator_seq_nbit;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       signed_mode;
  logic [7:0] A;
  logic [7:0] B;
  logic       busy;
  logic       done;
  logic       F1;
  logic       F2;
  logic       F3;

  int tests = 0;
  int fails = 0;

`ifdef CMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  comparator_seq_nbit #(.WIDTH(8), .DIGIT(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .A           (A),
    .B           (B),
    .busy        (busy),
    .done        (done),
    .F1          (F1),
    .F2          (F2),
    .F3          (F3)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for done after the accept edge; lat=255 means it never came.
  task automatic wait_done(output int lat);
    lat = 255;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic sm, input logic [2:0] expf, input int exp_lat);
    int lat;
    @(negedge clk);
    A = a; B = b; signed_mode = sm; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, 8'(busy), 8'd1);
    wait_done(lat);
    check({tag, "_lat"}, 8'(lat), 8'(exp_lat));
    check({tag, "_F"}, 8'({F1, F2, F3}), 8'(expf));
  endtask

  initial begin
    int lat;
    int seen;
    rst = 1'b1; start = 1'b0; signed_mode = 1'b0; A = '0; B = '0;

    // Reset state
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("reset_busy", 8'(busy), 8'd0);
    check("reset_done", 8'(done), 8'd0);
    check("reset_F", 8'({F1, F2, F3}), 8'd0);
    rst = 1'b0;

    // Reset mid-run (before any early-exit done can appear)
    @(negedge clk);
    A = 8'hA5; B = 8'h5A; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    if (!EARLY) begin
      @(negedge clk);
      if (done) seen++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 8'(busy), 8'd0);
    check("midrst_done", 8'(done), 8'd0);
    check("midrst_F", 8'({F1, F2, F3}), 8'd0);
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("midrst_no_done", 8'(seen), 8'd0);

    // Unsigned greater, equal, signed vs unsigned
    run_op("ugt",    8'hA5, 8'h5A, 1'b0, 3'b100, EARLY ? 1 : 4);
    run_op("eq",     8'h3C, 8'h3C, 1'b0, 3'b010, 4);
    run_op("s_lt",   8'h80, 8'h01, 1'b1, 3'b001, EARLY ? 1 : 4);
    run_op("u_gt",   8'h80, 8'h01, 1'b0, 3'b100, EARLY ? 1 : 4);
    run_op("s_neg",  8'hFE, 8'hFF, 1'b1, 3'b001, 4);
    run_op("s_pos",  8'h7F, 8'h80, 1'b1, 3'b100, EARLY ? 1 : 4);

    // start ignored while busy
    @(negedge clk);
    A = 8'h10; B = 8'h11; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    A = 8'hFF; B = 8'h00;
    @(negedge clk);
    start = 1'b0;
    check("ign_busy", 8'(busy), 8'd1);
    lat = 255;
    for (int n = 2; n <= 8; n++) begin
      if (done) begin
        lat = n - 1;
        break;
      end
      @(negedge clk);
    end
    if (lat == 255 && done) lat = 8;
    check("ign_lat", 8'(lat), 8'd4);
    check("ign_F", 8'({F1, F2, F3}), 8'b001);
    seen = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("ign_single_done", 8'(seen), 8'd0);
    check("ign_F_held", 8'({F1, F2, F3}), 8'b001);

    // Back-to-back: accept new start in the done cycle
    @(negedge clk);
    A = 8'h01; B = 8'h02; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    check("b2b_first_lat", 8'(lat), 8'd4);
    check("b2b_first_F", 8'({F1, F2, F3}), 8'b001);
    A = 8'h02; B = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", 8'(busy), 8'd1);
    check("b2b_done_low", 8'(done), 8'd0);
    check("b2b_F_held", 8'({F1, F2, F3}), 8'b001);
    wait_done(lat);
    check("b2b_second_lat", 8'(lat), 8'd4);
    check("b2b_second_F", 8'({F1, F2, F3}), 8'b100);

    @(negedge clk);
    check("idle_busy", 8'(busy), 8'd0);
    check("idle_done", 8'(done), 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
